wb_reg_bank: RTL and testbench
==============================

WB_REG_BANK -- requirements
Module: wb_reg_bank

Interface
REQ-001 Parameter NREGS, default 2, number of 32-bit registers, legal range 1..64.
REQ-002 Parameter ADR_W, default 1, word-address width, SHALL equal max(1, clog2(NREGS)).
REQ-003 Parameter RESET_VAL, default all zeros, NREGS*32-bit vector; register i resets to bits [32*i+31:32*i].
REQ-004 clk_i  input  1  sole clock, all logic on rising edge.
REQ-005 rst_n_i  input  1  reset, synchronous, active-low.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone cycle, strobe, write-enable.
REQ-007 wb_adr_i  input  [ADR_W+1:2]  word address.
REQ-008 wb_sel_i  input  4  byte enables; wb_dat_i  input  32  write data.
REQ-009 wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o  output  1 each  Wishbone response.
REQ-010 wb_dat_o  output  32  read data, registered.
REQ-011 reg_o  output  NREGS*32  current register contents, register i at [32*i+31:32*i].
REQ-012 reg_wr_o  output  NREGS  one-cycle pulse per register, set when that register was written.

Function
REQ-013 Access is enabled (en) when wb_cyc_i & wb_stb_i; a read request SHALL be issued only when en & ~wb_we_i and no read is in progress, and a write request only when en & wb_we_i and no write is in progress.
REQ-014 Read-in-progress and write-in-progress flags SHALL set on request and clear when the corresponding ack (or err) is returned.
REQ-015 Read latency: request in cycle T -> wb_ack_o=1 and wb_dat_o valid in T+1.
REQ-016 Read data for a mapped index i SHALL be register i; for an unmapped index (>= NREGS), 0.
REQ-017 Write pipeline: wb_adr_i, wb_dat_i, wb_sel_i and the write request registered in T+1; register updated and wb_ack_o=1 in T+2.
REQ-018 Write SHALL update only bytes whose wb_sel_i bit was 1; wb_sel_i=0000 acks with no data change.
REQ-019 reg_wr_o[i] SHALL pulse for exactly one cycle in T+2 for any write to mapped index i, including sel=0000.
REQ-020 wb_stall_o = en & ~(wb_ack_o | wb_err_o); wb_rty_o constant 0.
REQ-021 wb_ack_o and wb_err_o SHALL never be 1 in the same cycle and each SHALL be 1 for exactly one cycle per request.
REQ-022 Back-to-back: a new request accepted the cycle after its predecessor's ack SHALL obey REQ-015/REQ-017 with no lost or duplicated acks.
REQ-023 en deasserted before ack (aborted cycle): a pending ack is still produced once, and a write already registered still takes effect.

Reset
REQ-024 While rst_n_i=0 at a clock edge: registers <- RESET_VAL; wb_dat_o=0; wb_ack_o, wb_err_o, reg_wr_o, all in-progress flags and pipeline stages=0.
REQ-025 Reset asserted mid-transaction SHALL discard it: no ack/err after reset, register not modified.
REQ-026 The first request SHALL be accepted in the first cycle with rst_n_i=1.

Configuration
REQ-027 Macro WB_REG_BANK_ERR_EN defined: an access to an unmapped index SHALL return wb_err_o=1 (wb_ack_o=0) with the latency of REQ-015/REQ-017, and no register or reg_wr_o changes.
REQ-028 Macro undefined: an unmapped access SHALL return wb_ack_o=1, reads return 0, writes are discarded, and wb_err_o is constant 0.

Verification
REQ-029 NREGS=3, RESET_VAL={0x0,0x123,0xDEADBEEF}: release reset, read idx 0,1,2 -> 0xDEADBEEF, 0x123, 0x0, each ack one cycle after its request.
REQ-030 Write 0xAABBCCDD sel=0101 to idx 1 (reset 0x123) -> ack at T+2, reg_o idx1=0x00BB01DD, reg_wr_o=010 for one cycle, readback matches.
REQ-031 NREGS=3, write then read idx 3: without macro -> ack, read 0, no reg_wr_o; with WB_REG_BANK_ERR_EN -> err each time, ack 0.
REQ-032 Ten back-to-back alternating writes/reads with stb held high -> exactly ten single-cycle acks, wb_stall_o high only while awaiting ack, data correct.
REQ-033 Assert rst_n_i in T+1 of a write of 0xFFFFFFFF to idx 0 -> no ack, reg_o idx0 = RESET_VAL value, reg_wr_o stays 0.

Source files
------------

// File: rtl/wb_reg_bank.sv
// Wishbone-slave bank of NREGS 32-bit registers with byte-enable writes and per-register write pulses.
// Define WB_REG_BANK_ERR_EN to answer unmapped accesses with wb_err_o instead of a silent wb_ack_o.
module wb_reg_bank #(
    parameter int unsigned          NREGS     = 2,
    parameter int unsigned          ADR_W     = 1,
    parameter logic [NREGS*32-1:0]  RESET_VAL = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADR_W+1:2]      wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic                  wb_stall_o,
    output logic [31:0]           wb_dat_o,
    output logic [NREGS*32-1:0]   reg_o,
    output logic [NREGS-1:0]      reg_wr_o
);

    localparam int unsigned DW = 32;

    logic                    en;
    logic                    rd_req;
    logic                    wr_req;
    logic [DW-1:0]           rd_val;

    logic                    rd_busy_q, rd_busy_d;
    logic                    wr_busy_q, wr_busy_d;
    logic                    rd_done_q, rd_done_d;
    logic                    wr_done_q, wr_done_d;
    logic                    wr_stg_q,  wr_stg_d;
    logic [ADR_W-1:0]        wr_adr_q,  wr_adr_d;
    logic [DW-1:0]           wr_dat_q,  wr_dat_d;
    logic [3:0]              wr_sel_q,  wr_sel_d;
    logic [NREGS-1:0][DW-1:0] regs_q,   regs_d;
    logic [NREGS-1:0]        reg_wr_q,  reg_wr_d;
    logic                    ack_q,     ack_d;
    logic                    err_q,     err_d;
    logic [DW-1:0]           dat_q,     dat_d;

`ifdef WB_REG_BANK_ERR_EN
    localparam logic [ADR_W:0] NREGS_W = (ADR_W+1)'(NREGS);
    logic rd_map;
    logic wr_map;
    assign rd_map = ({1'b0, wb_adr_i} < NREGS_W);
    assign wr_map = ({1'b0, wr_adr_q} < NREGS_W);
`endif

    // Request decode, read mux, write stage and response generation
    always_comb begin
        en        = wb_cyc_i & wb_stb_i;
        rd_req    = en & ~wb_we_i & ~rd_busy_q;
        wr_req    = en &  wb_we_i & ~wr_busy_q;
        rd_val    = '0;
        regs_d    = regs_q;
        reg_wr_d  = '0;
        dat_d     = dat_q;
        wr_stg_d  = wr_req;
        wr_adr_d  = wr_adr_q;
        wr_dat_d  = wr_dat_q;
        wr_sel_d  = wr_sel_q;
        rd_done_d = rd_req;
        wr_done_d = wr_stg_q;
        rd_busy_d = rd_req | (rd_busy_q & ~rd_done_q);
        wr_busy_d = wr_req | (wr_busy_q & ~wr_done_q);

        // Unmapped indices match no entry: reads yield 0, writes are dropped
        for (int i = 0; i < NREGS; i++) begin
            if (wb_adr_i == ADR_W'(i)) begin
                rd_val = regs_q[i];
            end
            if (wr_stg_q && (wr_adr_q == ADR_W'(i))) begin
                reg_wr_d[i] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (wr_sel_q[b]) begin
                        regs_d[i][8*b +: 8] = wr_dat_q[8*b +: 8];
                    end
                end
            end
        end

        if (rd_req) begin
            dat_d = rd_val;
        end
        if (wr_req) begin
            wr_adr_d = wb_adr_i;
            wr_dat_d = wb_dat_i;
            wr_sel_d = wb_sel_i;
        end

`ifdef WB_REG_BANK_ERR_EN
        ack_d = (rd_req & rd_map) | (wr_stg_q & wr_map);
        err_d = (rd_req & ~rd_map) | (wr_stg_q & ~wr_map);
`else
        ack_d = rd_req | wr_stg_q;
        err_d = 1'b0;
`endif
    end

    // State registers; synchronous reset discards any in-flight transaction
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_busy_q <= 1'b0;
            wr_busy_q <= 1'b0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            wr_stg_q  <= 1'b0;
            wr_adr_q  <= '0;
            wr_dat_q  <= '0;
            wr_sel_q  <= '0;
            regs_q    <= RESET_VAL;
            reg_wr_q  <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            rd_busy_q <= rd_busy_d;
            wr_busy_q <= wr_busy_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            wr_stg_q  <= wr_stg_d;
            wr_adr_q  <= wr_adr_d;
            wr_dat_q  <= wr_dat_d;
            wr_sel_q  <= wr_sel_d;
            regs_q    <= regs_d;
            reg_wr_q  <= reg_wr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = en & ~(ack_q | err_q);
    assign wb_dat_o   = dat_q;
    assign reg_o      = regs_q;
    assign reg_wr_o   = reg_wr_q;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed scoreboard bench for wb_reg_bank (NREGS=3); honours WB_REG_BANK_ERR_EN for unmapped expectations.
module tb_wb_reg_bank;

    localparam int unsigned NREGS = 3;
    localparam int unsigned ADR_W = 2;
    localparam logic [NREGS*32-1:0] RST_VAL = {32'h0000_0000, 32'h0000_0123, 32'hDEAD_BEEF};

    logic                  clk;
    logic                  rst_n;
    logic                  cyc, stb, we;
    logic [ADR_W+1:2]      adr;
    logic [3:0]            sel;
    logic [31:0]           wdat;
    logic                  ack, err, rty, stall;
    logic [31:0]           rdat;
    logic [NREGS*32-1:0]   regs;
    logic [NREGS-1:0]      reg_wr;

    typedef struct {
        logic             ack;
        logic             err;
        logic             is_rd;
        logic [31:0]      dat;
        logic [NREGS-1:0] wr_mask;
        int               lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [NREGS];
    int          n_cmp;
    int          n_fail;

    wb_reg_bank #(
        .NREGS     (NREGS),
        .ADR_W     (ADR_W),
        .RESET_VAL (RST_VAL)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_sel_i   (sel),
        .wb_dat_i   (wdat),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_rty_o   (rty),
        .wb_stall_o (stall),
        .wb_dat_o   (rdat),
        .reg_o      (regs),
        .reg_wr_o   (reg_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREGS*32-1:0] mdl_flat();
        logic [NREGS*32-1:0] v;
        for (int i = 0; i < NREGS; i++) v[32*i +: 32] = mdl[i];
        return v;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NREGS; i++) mdl[i] = RST_VAL[32*i +: 32];
    endtask

    // Present a request in the cycle after the previous response and queue its expected outcome
    task automatic drive(input logic w, input int idx, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        bit   mapped;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = ADR_W'(idx);
        wdat  = d;
        sel   = s;
        mapped    = (idx < NREGS);
        e.is_rd   = !w;
        e.lat     = w ? 2 : 1;
`ifdef WB_REG_BANK_ERR_EN
        e.ack     = mapped;
        e.err     = !mapped;
`else
        e.ack     = 1'b1;
        e.err     = 1'b0;
`endif
        e.dat     = (!w && mapped) ? mdl[idx] : 32'h0;
        e.wr_mask = '0;
        if (w && mapped) begin
            e.wr_mask[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        end
        sb.push_back(e);
        #1;
        check("req_ack_clear", ack, 1'b0);
        check("req_err_clear", err, 1'b0);
        check("req_stall", stall, 1'b1);
        check("req_regwr_clear", reg_wr, '0);
    endtask

    // Wait (bounded) for the response, pop the scoreboard and compare
    task automatic await_resp(input string tag, input bit abort);
        exp_t e;
        int   n;
        bit   got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (ack || err) got = 1'b1;
            else begin
                check({tag, "_stall_wait"}, stall, cyc & stb);
                if (abort) begin
                    cyc = 1'b0;
                    stb = 1'b0;
                end
            end
        end
        if (!got || sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_timeout: observed no response expected response", tag);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_ack"}, ack, e.ack);
        check({tag, "_err"}, err, e.err);
        check({tag, "_stall_resp"}, stall, 1'b0);
        if (e.is_rd) check({tag, "_rdata"}, rdat, e.dat);
        else         check({tag, "_reg_wr"}, reg_wr, e.wr_mask);
        check({tag, "_reg_o"}, regs, mdl_flat());
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        cyc    = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        adr    = '0;
        sel    = '0;
        wdat   = '0;
        mdl_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rty", rty, 1'b0);
        check("rst_dat", rdat, 32'h0);
        check("rst_reg_wr", reg_wr, '0);
        check("rst_reg_o", regs, {32'h0, 32'h123, 32'hDEADBEEF});
        check("rst_stall_idle", stall, 1'b0);

        // Reads straight out of reset; the first is driven in the first cycle with rst_n high
        drive(1'b0, 0, 32'h0, 4'h0); await_resp("rd0", 1'b0);
        check("rd0_const", rdat, 32'hDEADBEEF);
        drive(1'b0, 1, 32'h0, 4'h0); await_resp("rd1", 1'b0);
        check("rd1_const", rdat, 32'h0000_0123);
        drive(1'b0, 2, 32'h0, 4'h0); await_resp("rd2", 1'b0);
        check("rd2_const", rdat, 32'h0);

        // Byte-masked write and readback
        drive(1'b1, 1, 32'hAABBCCDD, 4'b0101); await_resp("wr1_sel0101", 1'b0);
        check("wr1_reg1_const", regs[63:32], 32'h00BB01DD);
        check("wr1_reg_wr_const", reg_wr, 3'b010);
        @(posedge clk); #1;
        check("wr1_reg_wr_pulse_end", reg_wr, 3'b000);
        drive(1'b0, 1, 32'h0, 4'h0); await_resp("rd1_back", 1'b0);

        // Empty byte mask still acks and pulses reg_wr_o
        drive(1'b1, 2, 32'hFFFFFFFF, 4'b0000); await_resp("wr2_sel0000", 1'b0);
        check("wr2_sel0000_reg_wr_const", reg_wr, 3'b100);

        // Unmapped index 3
        drive(1'b1, 3, 32'h55AA55AA, 4'b1111); await_resp("wr3_unmapped", 1'b0);
        drive(1'b0, 3, 32'h0, 4'h0);           await_resp("rd3_unmapped", 1'b0);

        // Back-to-back alternating writes/reads with strobe held high
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                drive(1'b1, 2, 32'h1000_0000 + 32'(k * 32'h0101_0101), 4'b1111);
                await_resp("b2b_wr", 1'b0);
            end else begin
                drive(1'b0, 2, 32'h0, 4'h0);
                await_resp("b2b_rd", 1'b0);
            end
        end
        go_idle();

        // Aborted write still lands; aborted read still acks once
        drive(1'b1, 0, 32'h12345678, 4'b1111); await_resp("abort_wr", 1'b1);
        check("abort_wr_reg0_const", regs[31:0], 32'h12345678);
        drive(1'b0, 0, 32'h0, 4'h0); await_resp("abort_rd", 1'b1);
        go_idle();
        @(posedge clk); #1;
        check("abort_no_extra_ack", ack, 1'b0);

        // Reset landing in the write's second cycle cancels it
        @(posedge clk); #1;
        cyc  = 1'b1; stb = 1'b1; we = 1'b1;
        adr  = '0; wdat = 32'hFFFFFFFF; sel = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        cyc   = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("rstmid_ack", ack, 1'b0);
        check("rstmid_err", err, 1'b0);
        check("rstmid_reg_wr", reg_wr, '0);
        check("rstmid_reg0", regs[31:0], 32'hDEADBEEF);
        @(posedge clk); #1;
        check("rstmid_ack_late", ack, 1'b0);
        check("rstmid_reg_wr_late", reg_wr, '0);
        mdl_reset();
        check("rstmid_reg_o", regs, mdl_flat());

        // First request after the second reset release
        drive(1'b0, 0, 32'h0, 4'h0); await_resp("post_rst_rd0", 1'b0);
        go_idle();
        @(posedge clk); #1;
        check("end_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
